// File: rtl/btn_tx_scheduler_pkg.sv
// Shared constants for the button-driven transmit scheduler: FSM encoding,
// modulator command codes and button bit positions.
package btn_tx_scheduler_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [1:0] OP_START    = 2'b00;
  localparam logic [1:0] OP_STOP     = 2'b01;
  localparam logic [1:0] OP_NEXT_PAT = 2'b10;
  localparam logic [1:0] OP_CLR_PAT  = 2'b11;

  localparam int BTN_START    = 0;
  localparam int BTN_STOP     = 1;
  localparam int BTN_NEXT_PAT = 2;
  localparam int BTN_CLR_PAT  = 3;

  // Requests that may win arbitration in each granting state
  localparam logic [3:0] ELIG_IDLE = 4'b1101;
  localparam logic [3:0] ELIG_RUN  = 4'b0010;

  // Button index doubles as the command code, so a grant maps straight to cmd_op
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    if (oh[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/btn_tx_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: the search starts one past the
// previous winner and wraps, returning a one-hot grant.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [3:0] grant
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_grant + 2'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_tx_scheduler.sv
// Turns debounced button edges into modulator commands, tracks the
// transmit session and owns the data-pattern select.
module btn_tx_scheduler
  import btn_tx_scheduler_pkg::*;
#(
  parameter int PAT_W         = 3,
  parameter int START_TIMEOUT = 1000
) (
  input  logic             Myclk,
  input  logic             Myrst_n,
  input  logic [3:0]       btn_db,
  input  logic             mod_ready,
  input  logic             mod_busy,
  output logic             cmd_valid,
  output logic [1:0]       cmd_op,
  output logic [PAT_W-1:0] pattern_sel,
  output logic             tx_active,
  output logic [3:0]       pending,
  output logic             start_err
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [3:0]       btn_prev;
  logic             hist_valid;
  logic [3:0]       edges;
  logic [3:0]       eligible;
  logic [3:0]       grant;
  logic [1:0]       grant_idx;
  logic [1:0]       last_grant;
  logic [3:0]       clear_mask;
  logic [CNT_W-1:0] wait_cnt;

  // hist_valid masks the first clock after reset so held buttons never fire
  assign edges     = btn_db & ~btn_prev & {4{hist_valid}};
  assign cmd_valid = (state == ST_ISSUE);
  assign tx_active = (state == ST_RUN);
  assign grant_idx = onehot_to_idx(grant);

  always_comb begin
    eligible = '0;
    if (state == ST_IDLE) eligible = pending & ELIG_IDLE;
    if (state == ST_RUN)  eligible = pending & ELIG_RUN;
  end

  rr_arbiter4 u_arb (
    .req        (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    state_next = state;
    clear_mask = '0;
    case (state)
      ST_IDLE: begin
        clear_mask[BTN_STOP] = 1'b1;
        if (|grant) begin
          clear_mask = clear_mask | grant;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mod_ready) begin
          if (cmd_op == OP_START)     state_next = ST_WAIT_BUSY;
          else if (cmd_op == OP_STOP) state_next = ST_RUN;
          else                        state_next = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (mod_busy)                   state_next = ST_RUN;
        else if (wait_cnt == CNT_LAST)  state_next = ST_IDLE;
      end
      ST_RUN: begin
        // A session ending takes precedence over a STOP that is still queued
        clear_mask[BTN_START] = 1'b1;
        if (!mod_busy) begin
          clear_mask[BTN_STOP] = 1'b1;
          state_next           = ST_IDLE;
        end else if (|grant) begin
          clear_mask = clear_mask | grant;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Myclk or negedge Myrst_n) begin
    if (!Myrst_n) begin
      state       <= ST_IDLE;
      btn_prev    <= '0;
      hist_valid  <= 1'b0;
      pending     <= '0;
      last_grant  <= 2'd3;
      cmd_op      <= OP_START;
      pattern_sel <= '0;
      wait_cnt    <= '0;
      start_err   <= 1'b0;
    end else begin
      state      <= state_next;
      btn_prev   <= btn_db;
      hist_valid <= 1'b1;
      pending    <= (pending & ~clear_mask) | edges;
      if (state != ST_ISSUE && state_next == ST_ISSUE) begin
        cmd_op     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == ST_ISSUE && mod_ready) begin
        wait_cnt <= '0;
        if (cmd_op == OP_NEXT_PAT) pattern_sel <= pattern_sel + PAT_W'(1);
        if (cmd_op == OP_CLR_PAT)  pattern_sel <= '0;
      end
      if (state == ST_WAIT_BUSY && !mod_busy) begin
        if (wait_cnt == CNT_LAST) start_err <= 1'b1;
        else                      wait_cnt  <= wait_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/btn_tx_scheduler.md
BTN_TX_SCHEDULER -- requirements
Module: btn_tx_scheduler

Interface
REQ-001 Parameter PAT_W, default 3: width of the pattern-select register.
REQ-002 Parameter START_TIMEOUT, default 1000: maximum number of Myclk cycles to wait for mod_busy after a START transfer.
REQ-003 Myclk  in  1  single system clock; all state updates on its rising edge.
REQ-004 Myrst_n  in  1  reset, asynchronous, active-low.
REQ-005 btn_db  in  4  debounced button levels; bit0=START, bit1=STOP, bit2=NEXT_PAT, bit3=CLR_PAT.
REQ-006 mod_ready  in  1  modulator accepts a command this cycle.
REQ-007 mod_busy  in  1  modulator is transmitting.
REQ-008 cmd_valid  out  1  command offered to the modulator.
REQ-009 cmd_op  out  2  command code: 00 START, 01 STOP, 10 NEXT_PAT, 11 CLR_PAT.
REQ-010 pattern_sel  out  PAT_W  current data-pattern select driven to the modulator.
REQ-011 tx_active  out  1  high while FSM is in RUN.
REQ-012 pending  out  4  latched, not-yet-served requests.
REQ-013 start_err  out  1  sticky flag: START was accepted but mod_busy never rose within the timeout.

Function
REQ-014 Rising-edge detection: per btn_db bit, against the previous-cycle value; an edge sets pending[i] on the next clock.
REQ-015 Edge on an already-pending bit: coalesced, no second request.
REQ-016 Edge arriving in the same cycle its bit is cleared: pending stays set; the new edge wins.
REQ-017 Arbitration: round-robin over eligible pending bits; search starts at last_grant+1 mod 4; last_grant resets to 3, so bit0 has first priority.
REQ-018 FSM states: IDLE, ISSUE, WAIT_BUSY, RUN.
REQ-019 IDLE, eligible bits: START, NEXT_PAT, CLR_PAT.
REQ-020 IDLE, pending STOP: cleared without issuing a command.
REQ-021 IDLE: on any eligible grant, latch cmd_op, clear that pending bit, update last_grant, go to ISSUE next cycle.
REQ-022 ISSUE: cmd_valid=1 and cmd_op held stable until a cycle with mod_ready=1 (transfer); cmd_valid drops the cycle after the transfer.
REQ-023 ISSUE transfer, exit state: START goes to WAIT_BUSY; STOP goes to RUN, then ends as in REQ-025; NEXT_PAT and CLR_PAT go to IDLE.
REQ-024 WAIT_BUSY: count cycles from 0; mod_busy=1 goes to RUN; count reaching START_TIMEOUT-1 with mod_busy=0 sets start_err and goes to IDLE.
REQ-025 RUN: only STOP is eligible and is granted, going to ISSUE; mod_busy=0 sampled goes to IDLE.
REQ-026 RUN: START edges are dropped, cleared without issue.
REQ-027 RUN: NEXT_PAT and CLR_PAT remain pending until IDLE.
REQ-028 RUN, simultaneous pending STOP and mod_busy falling: go to IDLE and clear STOP.
REQ-029 pattern_sel on NEXT_PAT transfer: increments mod 2^PAT_W; value 2^PAT_W-1 wraps to 0.
REQ-030 pattern_sel on CLR_PAT transfer: set to 0.
REQ-031 pattern_sel: new value visible the cycle after the transfer; no other event changes it.
REQ-032 Grant latency: pending set at cycle N gives cmd_valid high at N+1 at the earliest.
REQ-033 start_err: cleared only by reset.

Reset
REQ-034 Myrst_n low asynchronously forces: FSM IDLE, cmd_valid 0, cmd_op 00, pattern_sel 0, tx_active 0, pending 0, start_err 0, timeout count 0, last_grant 3, edge-detect history 0.
REQ-035 Reset asserted mid-ISSUE: cmd_valid drops immediately, without waiting for the clock.
REQ-036 First clock after reset release: no edge is generated from buttons already held.

Structure
REQ-037 Shared package holds the FSM state encoding, the cmd_op code constants, and the button bit indices.
REQ-038 One sub-module, rr_arbiter4: 4-bit request vector plus last_grant in, one-hot grant out; purely combinational.

Verification
REQ-039 START pulse, mod_ready=1, mod_busy rises 3 cycles later -> one cmd_valid cycle with cmd_op=00; tx_active=1 from the cycle after mod_busy is sampled high.
REQ-040 Start in IDLE, pattern_sel=7, PAT_W=3; NEXT_PAT pulse, mod_ready=1 -> cmd_op=10 transfer; pattern_sel=0 the following cycle.
REQ-041 Start in IDLE; START, NEXT_PAT, CLR_PAT edges in the same cycle; START transfer followed by mod_busy=0 within the timeout window -> grants in order START (WAIT_BUSY, then timeout and start_err=1), NEXT_PAT, CLR_PAT; pattern_sel ends at 0.
REQ-042 In RUN, mod_ready=0 for 5 cycles, STOP pulse -> cmd_valid=1 with cmd_op=01 held 5 cycles and stable until mod_ready=1; RUN exits when mod_busy=0.
REQ-043 START accepted, mod_busy held 0, START_TIMEOUT=8 -> start_err=1 after 8 WAIT_BUSY cycles; back to IDLE; start_err persists until Myrst_n.
REQ-044 Myrst_n low during ISSUE -> cmd_valid=0 before the next clock edge; all outputs at reset values; held button produces no request after release.
